// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types for the multi-word add sequencer: FSM state encoding and
// the width of the settle counter.
package add_seq_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Operand-in / sum-out stream bundle for the multi-word add sequencer.
// The master drives operands and accepts sums; the slave is the sequencer.
interface multiword_add_sequencer_if #(parameter int N = 64);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_first;
    logic         in_last;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_last;
    logic         out_cout;
    logic         err_seq;

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_cout, err_seq
    );

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_cout, err_seq
    );

endinterface

// File: rtl/multiword_add_sequencer_adder.sv
// Combinational N-bit adder built from per-bit generate/propagate terms
// with a rippled carry chain.
module n_bit_pg_carry_ripple #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N-1:0] g;
    logic [N-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic cr;
        s  = '0;
        cr = cin;
        for (int i = 0; i < N; i++) begin
            s[i] = p[i] ^ cr;
            cr   = g[i] | (p[i] & cr);
        end
        cout = cr;
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Feeds registered operand chunks to a ripple adder, waits SETTLE edges for
// the multicycle carry path, then presents the sum with chunk-to-chunk carry chaining.
module multiword_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int N      = 64,
    parameter int SETTLE = 2
) (
    input logic                      clk,
    input logic                      rst,
    multiword_add_sequencer_if.slave bus
);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               capture;
    logic               release_beat;
    logic               idle_ready;

    logic [CNT_W-1:0]   cnt;
    logic               carry_r;
    logic               open_r;
    logic               err_r;

    logic [N-1:0]       a_p0;
    logic [N-1:0]       b_p0;
    logic               cin_p0;
    logic               last_p0;

    logic [N-1:0]       sum_c;
    logic               cout_c;

    logic               vld_p1;
    logic [N-1:0]       sum_p1;
    logic               cout_p1;
    logic               last_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        capture      = 1'b0;
        release_beat = 1'b0;
        idle_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                idle_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == CNT_W'(1)) begin
                    capture   = 1'b1;
                    state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    release_beat = 1'b1;
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_ready = idle_ready & ~rst;

    // p0: operand registers, the only drivers of the adder inputs
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0    <= bus.in_a;
            b_p0    <= bus.in_b;
            last_p0 <= bus.in_last;
            cin_p0  <= bus.in_first ? bus.in_cin : (open_r & carry_r);
        end
    end

    n_bit_pg_carry_ripple #(.N(N)) u_adder (
        .a    (a_p0),
        .b    (b_p0),
        .cin  (cin_p0),
        .s    (sum_c),
        .cout (cout_c)
    );

    // p1: captured result, held until the downstream handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            carry_r <= 1'b0;
            open_r  <= 1'b0;
            err_r   <= 1'b0;
            vld_p1  <= 1'b0;
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            if (accept) begin
                // A continuation with nothing open, or a new start over an open one
                if (bus.in_first == open_r) begin
                    err_r <= 1'b1;
                end
                open_r <= 1'b1;
                cnt    <= CNT_W'(SETTLE);
            end
            if (state == S_SETTLE) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                vld_p1  <= 1'b1;
                sum_p1  <= sum_c;
                cout_p1 <= cout_c;
                last_p1 <= last_p0;
            end
            if (release_beat) begin
                vld_p1 <= 1'b0;
                if (last_p1) begin
                    carry_r <= 1'b0;
                    open_r  <= 1'b0;
                end else begin
                    carry_r <= cout_p1;
                end
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_sum   = sum_p1;
    assign bus.out_cout  = cout_p1;
    assign bus.out_last  = last_p1;
    assign bus.err_seq   = err_r;

endmodule
